// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared width, counter terminal, state encoding and sign helpers for div_16bit
package div_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_TERM = 5'd16;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_t;

  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] x);
    return ~x + WIDTH'(1);
  endfunction

  // |-32768| wraps back to 0x8000, which is the correct unsigned magnitude
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? negate(x) : x;
  endfunction

endpackage

// File: rtl/sub_17bit.sv
// rtl/sub_17bit.sv - combinational WIDTH+1 bit subtractor: full adder chain, inverted subtrahend, carry-in 1
module sub_17bit
  import div_pkg::*;
(
  input  logic [WIDTH:0] i_a,
  input  logic [WIDTH:0] i_b,
  output logic [WIDTH:0] o_diff
);

  logic [WIDTH:0] w_b_n;
  logic [WIDTH:0] w_carry;

  assign w_b_n      = ~i_b;
  assign w_carry[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
    assign o_diff[i] = i_a[i] ^ w_b_n[i] ^ w_carry[i];
    if (i < WIDTH) begin : g_carry
      assign w_carry[i+1] = (i_a[i] & w_b_n[i]) | (w_carry[i] & (i_a[i] ^ w_b_n[i]));
    end
  end

endmodule

// File: rtl/div_16bit.sv
// rtl/div_16bit.sv - sequential signed restoring divider, one quotient bit per clock, 18-cycle op
module div_16bit
  import div_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_ready,
  output logic             o_busy,
  output logic             o_div_by_zero,
  output logic             o_ovf
);

  state_t           r_state;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_dvd_mag;   // dividend bits shift out the top, quotient bits shift in the bottom
  logic [WIDTH-1:0] r_dvs_mag;
  logic [WIDTH-1:0] r_part;
  logic [WIDTH-1:0] r_dividend;
  logic             r_sign_q;
  logic             r_sign_r;
  logic             r_dbz;
  logic             r_ovf;

  logic [WIDTH:0]   w_shifted;
  logic [WIDTH:0]   w_trial;
  logic             w_keep;
  logic [CNT_W-1:0] w_count_inc;

  assign w_shifted   = {r_part, r_dvd_mag[WIDTH-1]};
  assign w_keep      = ~w_trial[WIDTH];
  assign w_count_inc = r_count + CNT_W'(1);

  sub_17bit u_sub (
    .i_a    (w_shifted),
    .i_b    ({1'b0, r_dvs_mag}),
    .o_diff (w_trial)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= IDLE;
      r_count       <= '0;
      r_dvd_mag     <= '0;
      r_dvs_mag     <= '0;
      r_part        <= '0;
      r_dividend    <= '0;
      r_sign_q      <= 1'b0;
      r_sign_r      <= 1'b0;
      r_dbz         <= 1'b0;
      r_ovf         <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_ready       <= 1'b0;
      o_busy        <= 1'b0;
      o_div_by_zero <= 1'b0;
      o_ovf         <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          o_ready <= 1'b0;
          if (i_start) begin
            r_dividend <= i_dividend;
            r_dvd_mag  <= magnitude(i_dividend);
            r_dvs_mag  <= magnitude(i_divisor);
            r_sign_q   <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
            r_sign_r   <= i_dividend[WIDTH-1];
            r_dbz      <= (i_divisor == '0);
            r_ovf      <= (i_dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (i_divisor == '1);
            r_part     <= '0;
            r_count    <= '0;
            o_busy     <= 1'b1;
            r_state    <= DIVIDE;
          end
        end
        DIVIDE: begin
          r_dvd_mag <= {r_dvd_mag[WIDTH-2:0], w_keep};
          r_part    <= w_keep ? w_trial[WIDTH-1:0] : w_shifted[WIDTH-1:0];
          r_count   <= w_count_inc;
          if (w_count_inc == CNT_TERM) begin
            r_state <= FINISH;
          end
        end
        FINISH: begin
          // A zero divisor leaves q=all ones in the datapath; the result is overridden here
          if (r_dbz) begin
            o_quotient  <= '0;
            o_remainder <= r_dividend;
          end else begin
            o_quotient  <= r_sign_q ? negate(r_dvd_mag) : r_dvd_mag;
            o_remainder <= r_sign_r ? negate(r_part) : r_part;
          end
          o_div_by_zero <= r_dbz;
          o_ovf         <= r_ovf;
          o_ready       <= 1'b1;
          o_busy        <= 1'b0;
          r_state       <= IDLE;
        end
        default: begin
          r_state <= IDLE;
          o_busy  <= 1'b0;
          o_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_16bit.sv
// tb/tb_div_16bit.sv - self-checking bench for div_16bit against an integer-arithmetic reference
module tb_div_16bit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] dividend = '0;
  logic [15:0] divisor = '0;
  logic [15:0] quotient;
  logic [15:0] remainder;
  logic        ready;
  logic        busy;
  logic        div_by_zero;
  logic        ovf;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  div_16bit dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_dividend    (dividend),
    .i_divisor     (divisor),
    .o_quotient    (quotient),
    .o_remainder   (remainder),
    .o_ready       (ready),
    .o_busy        (busy),
    .o_div_by_zero (div_by_zero),
    .o_ovf         (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [15:0] a, input logic [15:0] b,
                                output logic [15:0] q, output logic [15:0] r,
                                output logic dz, output logic ov);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    dz = 1'b0;
    ov = 1'b0;
    if (b == 16'h0000) begin
      q = 16'h0000; r = a; dz = 1'b1;
    end else if (a == 16'h8000 && b == 16'hFFFF) begin
      q = 16'h8000; r = 16'h0000; ov = 1'b1;
    end else begin
      q = 16'(sa / sb);
      r = 16'(sa % sb);
    end
  endfunction

  // Drive a start, return just after the accepting edge with start dropped unless held
  task automatic op_start(input logic [15:0] a, input logic [15:0] b, input bit hold);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    #1;
    chk("busy_after_accept", busy, 1'b1);
    start = hold;
    dividend = 16'($urandom);
    divisor  = 16'($urandom);
  endtask

  task automatic wait_check(input logic [15:0] a, input logic [15:0] b, input int lat, input string tag);
    logic [15:0] eq, er;
    logic edz, eov;
    int n;
    model(a, b, eq, er, edz, eov);
    n = 0;
    while (ready !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
    chk({tag, "_quotient"}, quotient, eq);
    chk({tag, "_remainder"}, remainder, er);
    chk({tag, "_dbz"}, div_by_zero, edz);
    chk({tag, "_ovf"}, ovf, eov);
    chk({tag, "_busy_at_ready"}, busy, 1'b0);
  endtask

  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input string tag);
    op_start(a, b, 1'b0);
    wait_check(a, b, 17, tag);
    @(posedge clk);
    #1;
    chk({tag, "_ready_one_cycle"}, ready, 1'b0);
    chk({tag, "_busy_after"}, busy, 1'b0);
  endtask

  initial begin
    logic [15:0] ra, rb;
    bit seen;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_quotient", quotient, 16'h0000);
    chk("reset_remainder", remainder, 16'h0000);
    chk("reset_ready", ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_dbz", div_by_zero, 1'b0);
    chk("reset_ovf", ovf, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    do_op(16'd100, 16'd7, "p100_7");
    chk("p100_7_const_q", quotient, 16'h000E);
    do_op(16'hFF9C, 16'd7, "m100_7");
    chk("m100_7_const_r", remainder, 16'hFFFE);
    do_op(16'd100, 16'hFFF9, "p100_m7");
    chk("p100_m7_const_q", quotient, 16'hFFF2);
    do_op(16'd1234, 16'd0, "dbz");
    do_op(16'h8000, 16'hFFFF, "ovf");
    do_op(16'h8000, 16'd2, "min_by_2");
    chk("min_by_2_const_q", quotient, 16'hC000);

    // Second start inside the operation must be ignored
    op_start(16'd1000, 16'd3, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; dividend = 16'd77; divisor = 16'd5;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_check(16'd1000, 16'd3, 12, "ignored_start");

    // Start held through the ready cycle is accepted on the following edge
    op_start(16'hF000, 16'd9, 1'b1);
    dividend = 16'd5000; divisor = 16'hFFFD;
    wait_check(16'hF000, 16'd9, 17, "held_first");
    @(posedge clk);
    #1;
    chk("held_accept_busy", busy, 1'b1);
    chk("held_accept_ready", ready, 1'b0);
    start = 1'b0;
    wait_check(16'd5000, 16'hFFFD, 17, "held_second");

    // Reset in the middle of an operation
    op_start(16'd30000, 16'd7, 1'b0);
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_quotient", quotient, 16'h0000);
    chk("midrst_remainder", remainder, 16'h0000);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ready, 1'b0);
    chk("midrst_flags", {div_by_zero, ovf}, 2'b00);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      seen = seen | ready;
    end
    chk("midrst_no_ready", seen, 1'b0);
    do_op(16'hFFFF, 16'd1, "m1_1");

    for (int i = 0; i < 16; i++) begin
      ra = 16'($urandom);
      rb = (i % 5 == 4) ? 16'h0000 : 16'($urandom);
      if (i % 3 == 0) rb = 16'($urandom_range(1, 40));
      if (i % 7 == 6) rb = 16'hFFF0 | 16'($urandom_range(0, 15));
      do_op(ra, rb, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/div_16bit.md
# div_16bit

Sequential signed 16-bit divider: the inverse operation of the team's ripple-carry adder datapath, reusing subtraction (adder plus inverted operand and carry-in) one bit per cycle. It sits beside the adder in the ALU's multi-cycle unit. It accepts a dividend/divisor pair on a start strobe and returns the quotient and remainder with a one-cycle ready pulse after a fixed latency. It also flags divide-by-zero and the single overflow case.

## Interface
- WIDTH, 16, operand width; only even values ≥ 4 are supported; all values below assume 16.
- clock  in  1  sole clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high; clears all state and outputs.
- start  in  1  request strobe; sampled only when busy=0.
- dividend  in  16  two's-complement dividend; latched on accepted start.
- divisor  in  16  two's-complement divisor; latched on accepted start.
- quotient  out  16  registered result; held until next completion.
- remainder  out  16  registered result; held until next completion.
- ready  out  1  one-cycle pulse marking new quotient/remainder/flags.
- busy  out  1  high from the edge accepting start through the edge raising ready.
- div_by_zero  out  1  set with ready when divisor=0; held with results.
- ovf  out  1  set with ready for -32768 / -1; held with results.

## Operation
- States: IDLE, DIVIDE, FINISH.
  - IDLE: on start=1, latch operands, record sign_q = sign(dividend) XOR sign(divisor), sign_r = sign(dividend).
  - Also in IDLE: load magnitude registers with |dividend| and |divisor| as 16-bit unsigned (|-32768| = 0x8000). Clear the 17-bit partial remainder and the 5-bit counter. Go to DIVIDE.
- DIVIDE: restoring division, one quotient bit per edge, MSB first, 16 edges.
  - Shift partial remainder left, bringing in the next dividend magnitude bit.
  - Compute trial = partial − {0, divisor magnitude} in 17 bits.
  - If trial is non-negative: keep trial and set the quotient bit to 1. Otherwise keep the shifted value and set the bit to 0.
  - After the 16th iteration go to FINISH.
- FINISH: apply signs and load the output registers; ready=1 for this one cycle; busy drops; return to IDLE.
  - quotient = sign_q ? −q_mag : q_mag.
  - remainder = sign_r ? −r_mag : r_mag.
  - Rounding is truncation toward zero; the remainder takes the sign of the dividend.
- Divide-by-zero: latency is unchanged. Result is quotient=0x0000, remainder=dividend, div_by_zero=1, ovf=0.
- Overflow (0x8000 / 0xFFFF): quotient=0x8000 (wrapped), remainder=0x0000, ovf=1, div_by_zero=0.
- start while busy=1 is ignored, including during FINISH. Operand changes after acceptance are ignored.
- Flags clear only on the next completion or on reset.

## Timing
- Reset values:
  - quotient=0, remainder=0.
  - ready=0, busy=0.
  - div_by_zero=0, ovf=0.
  - state=IDLE.
- Latency: start accepted at edge k, iterations on edges k+1..k+16, outputs and ready=1 loaded at edge k+17. ready is visible in the cycle after edge k+17.
- busy is 1 in cycles following edges k..k+16 and 0 after edge k+17.
- Throughput: a start held high through the ready cycle is accepted at edge k+18. Maximum rate is one operation per 18 cycles.
- Reset asserted mid-operation: immediate return to reset values; no ready pulse. The first start after reset deasserts is accepted normally.

## Structure
- Shared package div_pkg holds:
  - the state encoding constants (IDLE=2'd0, DIVIDE=2'd1, FINISH=2'd2);
  - WIDTH;
  - the counter terminal value 16.
- One sub-module: sub_17bit, a combinational 17-bit subtractor built from the team's full adder chain with inverted subtrahend and carry-in=1. It is used for the trial subtraction. Sign negation may share it or use a separate increment.
- Top level contains only the state register, counter, operand/remainder shift registers and output registers.

## Test plan
- 100 / 7: start at edge k → at edge k+17 quotient=0x000E, remainder=0x0002, ready pulse for exactly 1 cycle, busy low after.
- −100 / 7 and 100 / −7: quotient=0xFFF2 for both; remainder=0xFFFE for −100/7 and 0x0002 for 100/−7.
- 1234 / 0: quotient=0x0000, remainder=0x04D2, div_by_zero=1, ovf=0, same 17-edge latency.
- −32768 / −1: quotient=0x8000, remainder=0x0000, ovf=1. Follow with −32768 / 2: quotient=0xC000, ovf clears.
- Second start pulse at edge k+5 with different operands: ignored, first result unchanged. start held through the ready cycle: accepted at edge k+18.
- Reset asserted at edge k+8: all outputs 0, busy=0, no ready pulse. A new 65535-pattern test, −1 / 1, then returns quotient=0xFFFF, remainder=0x0000.
